pc_control: RTL and testbench

- Next-PC and condition-flag stage of the single-cycle 16-bit CPU.
- Holds the PC register, the Z/V/N flag register and the halt latch.
- Consumes the decoder's PC-source select plus the opcode, condition field, branch immediate, BR register value and ALU flag outputs.
- Feeds the instruction-memory address and the PC+2 value used by PCS.

---
 rtl/cpu_pkg.sv | 18 +
 rtl/branch_cond_eval.sv | 26 ++
 rtl/pc_control.sv | 58 +++++
 tb/tb_pc_control.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared opcode, condition-code, PC-source and flag-index constants for the 16-bit CPU
package cpu_pkg;
  typedef enum logic [3:0] {
    OP_ADD = 4'h0, OP_SUB = 4'h1, OP_XOR = 4'h2, OP_RED = 4'h3,
    OP_SLL = 4'h4, OP_SRA = 4'h5, OP_ROR = 4'h6, OP_PADDSB = 4'h7,
    OP_LW  = 4'h8, OP_SW  = 4'h9, OP_LLB = 4'hA, OP_LHB = 4'hB,
    OP_B   = 4'hC, OP_BR  = 4'hD, OP_PCS = 4'hE, OP_HLT = 4'hF
  } opcode_e;
  typedef enum logic [2:0] {
    CC_NE, CC_EQ, CC_GT, CC_LT, CC_GE, CC_LE, CC_OV, CC_UNCOND
  } cond_e;
  typedef enum logic [1:0] {
    PCS_SEQ = 2'b00, PCS_REG = 2'b01, PCS_RSVD = 2'b10, PCS_IMM = 2'b11
  } pc_source_e;
  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_N = 0;
endpackage

// File: rtl/branch_cond_eval.sv
// branch_cond_eval: decides whether a branch condition holds for the registered {Z,V,N} flags
module branch_cond_eval
  import cpu_pkg::*;
(
  input  logic [2:0] cond,
  input  logic [2:0] flags,
  output logic       taken
);
  logic w_z, w_v, w_n;
  assign w_z = flags[FLAG_Z];
  assign w_v = flags[FLAG_V];
  assign w_n = flags[FLAG_N];
  always_comb begin
    taken = 1'b1;
    case (cond_e'(cond))
      CC_NE:   taken = !w_z;
      CC_EQ:   taken = w_z;
      CC_GT:   taken = !w_z && !w_n;
      CC_LT:   taken = w_n;
      CC_GE:   taken = w_z || (!w_z && !w_n);
      CC_LE:   taken = w_n || w_z;
      CC_OV:   taken = w_v;
      default: taken = 1'b1;
    endcase
  end
endmodule

// File: rtl/pc_control.sv
// pc_control: PC register, {Z,V,N} flag register and sticky halt latch of the single-cycle CPU
module pc_control
  import cpu_pkg::*;
#(
  parameter int            DW       = 16,
  parameter logic [DW-1:0] RESET_PC = '0
)(
  input  logic          clk,
  input  logic          rst,
  input  logic [3:0]    opcode,
  input  logic [2:0]    cond,
  input  logic [8:0]    imm9,
  input  logic [1:0]    pc_source,
  input  logic [DW-1:0] br_target,
  input  logic          alu_z,
  input  logic          alu_v,
  input  logic          alu_n,
  output logic [DW-1:0] pc,
  output logic [DW-1:0] pc_plus2,
  output logic [2:0]    flags,
  output logic          halted
);
  logic [DW-1:0] r_pc, w_pc_next, w_pc_plus2, w_b_off, w_b_target;
  logic [2:0]    r_flags, w_flags_next;
  logic          r_halted, w_hlt, w_taken;
  opcode_e       w_op;
  assign w_op       = opcode_e'(opcode);
  assign w_hlt      = w_op == OP_HLT;
  assign w_pc_plus2 = r_pc + DW'(2);
  // imm9 is a word offset: sign-extend and scale to bytes in one concatenation
  assign w_b_off    = {{(DW-10){imm9[8]}}, imm9, 1'b0};
  assign w_b_target = w_pc_plus2 + w_b_off;
  branch_cond_eval u_cond (.cond(cond), .flags(r_flags), .taken(w_taken));
  always_comb begin
    w_pc_next = w_hlt ? r_pc :
                !w_taken ? w_pc_plus2 :
                pc_source == PCS_IMM ? w_b_target :
                pc_source == PCS_REG ? br_target : w_pc_plus2;
    w_flags_next = r_flags;
    if (w_op inside {OP_ADD, OP_SUB}) w_flags_next = {alu_z, alu_v, alu_n};
    else if (w_op inside {OP_XOR, OP_SLL, OP_SRA, OP_ROR}) w_flags_next[FLAG_Z] = alu_z;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc     <= RESET_PC;
      r_flags  <= '0;
      r_halted <= 1'b0;
    end else if (!r_halted) begin
      r_pc     <= w_pc_next;
      r_flags  <= w_flags_next;
      r_halted <= w_hlt;
    end
  end
  assign pc       = r_pc;
  assign pc_plus2 = w_pc_plus2;
  assign flags    = r_flags;
  assign halted   = r_halted;
endmodule

// File: tb/tb_pc_control.sv
// tb_pc_control: directed test-plan sequences plus random instruction streams against a behavioural model
module tb_pc_control;
  logic        clk = 1'b0, rst = 1'b1;
  logic [3:0]  opcode = '0;
  logic [2:0]  cond = '0;
  logic [8:0]  imm9 = '0;
  logic [1:0]  pc_source = '0;
  logic [15:0] br_target = '0;
  logic        alu_z = 1'b0, alu_v = 1'b0, alu_n = 1'b0;
  logic [15:0] pc, pc_plus2;
  logic [2:0]  flags;
  logic        halted;
  int n_chk = 0, n_pass = 0;
  int m_pc = 0;
  bit m_z, m_v, m_n, m_halt;

  pc_control #(.DW(16), .RESET_PC(16'h0000)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .cond(cond), .imm9(imm9),
    .pc_source(pc_source), .br_target(br_target), .alu_z(alu_z), .alu_v(alu_v),
    .alu_n(alu_n), .pc(pc), .pc_plus2(pc_plus2), .flags(flags), .halted(halted)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  function automatic bit cond_true(input int c);
    case (c)
      0: return !m_z;
      1: return m_z;
      2: return !m_z && !m_n;
      3: return m_n;
      4: return m_z || (!m_z && !m_n);
      5: return m_n || m_z;
      6: return m_v;
      default: return 1'b1;
    endcase
  endfunction

  task automatic check_all(input string where);
    chk({where, ".pc"}, 32'(pc), 32'(m_pc));
    chk({where, ".pc_plus2"}, 32'(pc_plus2), 32'((m_pc + 2) % 65536));
    chk({where, ".flags"}, 32'(flags), {29'd0, m_z, m_v, m_n});
    chk({where, ".halted"}, 32'(halted), 32'(m_halt));
  endtask

  task automatic model_reset();
    m_pc = 0; m_z = 0; m_v = 0; m_n = 0; m_halt = 0;
  endtask

  // one instruction: drive, clock, advance model, compare
  task automatic step(input int op, input int cc, input int im, input int ps,
                      input int br, input bit z, input bit v, input bit n);
    int off, nxt;
    opcode = 4'(op); cond = 3'(cc); imm9 = 9'(im); pc_source = 2'(ps);
    br_target = 16'(br); alu_z = z; alu_v = v; alu_n = n;
    off = (im >= 256) ? im - 512 : im;
    nxt = m_pc + 2;
    if (!m_halt) begin
      if (op == 15) m_halt = 1;
      else begin
        if (ps == 3 && cond_true(cc)) nxt = m_pc + 2 + 2 * off;
        else if (ps == 1 && cond_true(cc)) nxt = br;
        m_pc = ((nxt % 65536) + 65536) % 65536;
        if (op == 0 || op == 1) begin m_z = z; m_v = v; m_n = n; end
        else if (op == 2 || op == 4 || op == 5 || op == 6) m_z = z;
      end
    end
    @(posedge clk);
    #1;
    check_all("step");
  endtask

  task automatic async_reset(input string where);
    #3 rst = 1'b1;
    #1 model_reset();
    check_all(where);
    @(negedge clk) rst = 1'b0;
  endtask

  task automatic jump(input int target);
    step(13, 7, 0, 1, target, 0, 0, 0);
  endtask

  initial begin
    int halt_age;
    model_reset();
    #12 check_all("por");
    @(negedge clk) rst = 1'b0;
    // sequential run and async reset mid-run
    step(0, 0, 0, 0, 0, 0, 0, 0); chk("seq1", 32'(pc), 32'h2);
    step(0, 0, 0, 0, 0, 0, 0, 0); chk("seq2", 32'(pc), 32'h4);
    step(0, 0, 0, 0, 0, 1, 1, 1); chk("seq3", 32'(pc), 32'h6);
    jump(16'h0040); chk("at40", 32'(pc), 32'h40);
    async_reset("rst_mid");
    // wrap
    jump(16'hFFFE); chk("at_fffe", 32'(pc_plus2), 32'h0);
    step(0, 0, 0, 0, 0, 0, 0, 0); chk("wrap", 32'(pc), 32'h0);
    // flags and B
    jump(16'h000E);
    step(1, 0, 0, 0, 0, 1, 0, 0); chk("sub_flags", 32'(flags), 32'h4);
    step(12, 1, 9'h004, 3, 0, 0, 0, 0); chk("b_eq", 32'(pc), 32'h1A);
    jump(16'h0010);
    step(12, 0, 9'h004, 3, 0, 0, 0, 0); chk("b_ne_untaken", 32'(pc), 32'h12);
    jump(16'h0020);
    step(12, 7, 9'h1FE, 3, 0, 0, 0, 0); chk("b_back", 32'(pc), 32'h1E);
    step(12, 7, 9'h1FF, 3, 0, 0, 0, 0); chk("b_m1", 32'(pc), 32'h1E);
    step(12, 7, 9'h0FF, 3, 0, 0, 0, 0); chk("b_max", 32'(pc), 32'h1E + 2 + 510);
    // partial flag update
    step(0, 0, 0, 0, 0, 0, 1, 1); chk("add_flags", 32'(flags), 32'h3);
    step(2, 0, 0, 0, 0, 1, 0, 0); chk("xor_flags", 32'(flags), 32'h7);
    step(8, 0, 0, 0, 0, 0, 0, 0); chk("lw_flags", 32'(flags), 32'h7);
    // BR
    step(13, 3, 0, 1, 16'h1234, 0, 0, 0); chk("br_lt", 32'(pc), 32'h1234);
    step(0, 0, 0, 0, 0, 0, 0, 1);
    step(13, 6, 0, 1, 16'h4444, 0, 0, 0); chk("br_ov_untaken", 32'(pc), 32'h1238);
    step(13, 7, 0, 2, 16'h4444, 0, 0, 0); chk("pcs_rsvd", 32'(pc), 32'h123A);
    // halt
    jump(16'h0030);
    step(15, 7, 0, 1, 16'h5555, 1, 1, 1); chk("hlt_pc", 32'(pc), 32'h30);
    chk("hlt_flag", 32'(halted), 32'h1);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, 0, 0, 1, 1, 1);
      step(12, 7, 9'h010, 3, 0, 1, 1, 1);
    end
    chk("halt_hold", 32'(pc), 32'h30);
    async_reset("rst_halt");
    // random instruction streams
    halt_age = 0;
    for (int i = 0; i < 600; i++) begin
      int op;
      op = $urandom_range(0, 15);
      if (op == 15 && $urandom_range(0, 3) != 0) op = 0;
      step(op, $urandom_range(0, 7), $urandom_range(0, 511), $urandom_range(0, 3),
           $urandom_range(0, 65535), 1'($urandom), 1'($urandom), 1'($urandom));
      halt_age = m_halt ? halt_age + 1 : 0;
      if (halt_age > 3) begin
        async_reset("rst_rand");
        halt_age = 0;
      end
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
